button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 91 +++++++++
 tb/tb_button_conditioner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel 2-flop sync, debounce and press/release/long/repeat events.
// Define AUTO_REPEAT_EN to build the held-button repeat counter; otherwise btn_repeat is tied low.
module button_conditioner #(
  parameter int NUM_BTN           = 2,
  parameter int DEBOUNCE_CYCLES   = 270000,
  parameter int LONG_PRESS_CYCLES = 13500000,
  parameter int REPEAT_CYCLES     = 2700000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_repeat
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = LONG_PRESS_CYCLES > 1 ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_PRESS_CYCLES - 1);
  if (NUM_BTN < 1 || NUM_BTN > 8 || DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 1 || REPEAT_CYCLES < 1)
    $error("button_conditioner: parameter out of range");
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic [1:0] sync;
    logic level, rise, fall, press_q, rel_q, long_q, long_d, rpt_q;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt, hcnt_d;
    state_t state, state_d;
    // rise/fall mark the edge on which the debounced level is about to toggle
    assign rise = sync[1] & ~level & (dcnt == DMAX);
    assign fall = ~sync[1] & level & (dcnt == DMAX);
    always_comb begin
      state_d = state;
      hcnt_d  = '0;
      long_d  = 1'b0;
      if (fall) state_d = IDLE;
      else if (state == IDLE) state_d = rise ? PRESSED : IDLE;
      else if (state == PRESSED) begin
        long_d  = hcnt == HMAX;
        state_d = long_d ? HELD : PRESSED;
        hcnt_d  = long_d ? '0 : hcnt + 1'b1;
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        sync    <= '0;
        level   <= 1'b0;
        dcnt    <= '0;
        state   <= IDLE;
        hcnt    <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        sync    <= {sync[0], ~btn[i]};
        level   <= level ^ (rise | fall);
        dcnt    <= (sync[1] == level || dcnt == DMAX) ? '0 : dcnt + 1'b1;
        state   <= state_d;
        hcnt    <= hcnt_d;
        press_q <= rise;
        rel_q   <= fall;
        long_q  <= long_d;
      end
    end
`ifdef AUTO_REPEAT_EN
    localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rcnt;
    logic rpt_d;
    assign rpt_d = (state == HELD) & ~fall & (rcnt == RMAX);
    always_ff @(posedge clk) begin
      if (rst) begin
        rcnt  <= '0;
        rpt_q <= 1'b0;
      end else begin
        rcnt  <= (state != HELD || fall || rpt_d) ? '0 : rcnt + 1'b1;
        rpt_q <= rpt_d;
      end
    end
`else
    assign rpt_q = 1'b0;
`endif
    assign btn_level[i]   = level;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;
    assign btn_long[i]    = long_q;
    assign btn_repeat[i]  = rpt_q;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random pin stimulus checked every cycle against a timing-rule model.
module tb_button_conditioner;
  localparam int N = 2;
  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] btn = '1;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;
  int checks = 0;
  int errors = 0;
  button_conditioner #(.NUM_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .btn(btn), .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_long(btn_long), .btn_repeat(btn_repeat)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
  function automatic void chk(string name, logic [N-1:0] got, logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endfunction
  function automatic void chk_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endfunction
  // Model: level flips once the synchronised pin has disagreed with it for D straight cycles;
  // events are derived from the age of the current press.
  logic [N-1:0] e_level = '0, e_press = '0, e_rel = '0, e_long = '0, e_rpt = '0;
  logic [N-1:0] p1 = '0, p2 = '0;
  logic [D-1:0] hist [N];
  int t_press [N];
  int cyc = 0;
  always @(posedge clk) begin
    cyc++;
    e_press = '0;
    e_rel   = '0;
    e_long  = '0;
    e_rpt   = '0;
    if (rst) begin
      p1 = '0;
      p2 = '0;
      e_level = '0;
      for (int c = 0; c < N; c++) hist[c] = '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        hist[c] = {hist[c][D-2:0], p2[c]};
        p2[c] = p1[c];
        p1[c] = ~btn[c];
        if (hist[c] == {D{~e_level[c]}}) begin
          e_level[c] = ~e_level[c];
          if (e_level[c]) begin
            e_press[c] = 1'b1;
            t_press[c] = cyc;
          end else e_rel[c] = 1'b1;
        end else if (e_level[c]) begin
          int age;
          age = cyc - t_press[c];
          e_long[c] = age == L;
`ifdef AUTO_REPEAT_EN
          e_rpt[c] = age > L && (age - L) % R == 0;
`endif
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("level", btn_level, e_level);
    chk("press", btn_press, e_press);
    chk("release", btn_release, e_rel);
    chk("long", btn_long, e_long);
    chk("repeat", btn_repeat, e_rpt);
  end
  function automatic logic [N-1:0] sig(int sel);
    return sel == 0 ? btn_level : sel == 1 ? btn_press : sel == 2 ? btn_release :
           sel == 3 ? btn_long : btn_repeat;
  endfunction
  // Counts rising edges until the selected output bit reads 1; -1 if the bound expires.
  task automatic wait_for(input int sel, input int c, input int lim, output int n);
    logic [N-1:0] v;
    n = -1;
    for (int k = 1; k <= lim; k++) begin
      @(posedge clk);
      #1;
      v = sig(sel);
      if (v[c]) begin
        n = k;
        break;
      end
    end
  endtask
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    int n;
    logic [N-1:0] acc;
    for (int c = 0; c < N; c++) hist[c] = '0;
    step(3);
    rst = 1'b0;
    acc = '0;
    for (int k = 0; k < 50; k++) begin
      step(1);
      acc |= btn_level | btn_press | btn_release | btn_long | btn_repeat;
    end
    chk("idle_outputs", acc, 2'b00);
    btn[0] = 1'b0;
    wait_for(1, 0, 20, n);
    chk_int("press0_latency", n, D + 2);
    chk("press0_vec", btn_press, 2'b01);
    chk("level0_with_press", btn_level, 2'b01);
    step(1);
    chk("press0_one_cycle", btn_press, 2'b00);
    step(3);
    btn[0] = 1'b1;
    wait_for(2, 0, 20, n);
    chk_int("release0_latency", n, D + 2);
    chk("long0_absent", btn_long, 2'b00);
    step(10);
    acc = '0;
    for (int w = 1; w <= 3; w++) begin
      btn[0] = 1'b0;
      for (int k = 0; k < w; k++) begin
        step(1);
        acc |= btn_level | btn_press;
      end
      btn[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
        step(1);
        acc |= btn_level | btn_press;
      end
    end
    chk("glitch_ignored", acc, 2'b00);
    btn[1] = 1'b0;
    wait_for(1, 1, 20, n);
    chk_int("press1_latency", n, D + 2);
    wait_for(3, 1, 40, n);
    chk_int("long1_after_press", n, L);
`ifdef AUTO_REPEAT_EN
    wait_for(4, 1, 20, n);
    chk_int("repeat1_first", n, R);
    wait_for(4, 1, 20, n);
    chk_int("repeat1_period", n, R);
`else
    wait_for(4, 1, 20, n);
    chk_int("repeat1_disabled", n, -1);
`endif
    step(12);
    btn[1] = 1'b1;
    wait_for(2, 1, 20, n);
    chk_int("release1_latency", n, D + 2);
    wait_for(4, 1, 20, n);
    chk_int("repeat1_stopped", n, -1);
    btn = 2'b00;
    wait_for(1, 0, 20, n);
    chk("press_both", btn_press, 2'b11);
    step(5);
    btn[0] = 1'b1;
    wait_for(2, 0, 20, n);
    chk("release_ch0_only", btn_release, 2'b01);
    step(5);
    btn[1] = 1'b1;
    wait_for(2, 1, 20, n);
    chk("release_ch1_only", btn_release, 2'b10);
    step(10);
    btn[0] = 1'b0;
    wait_for(3, 0, 60, n);
    chk_int("long0_reached", n == -1 ? 0 : 1, 1);
    step(3);
    rst = 1'b1;
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      acc |= btn_level | btn_press | btn_release | btn_long | btn_repeat;
    end
    chk("reset_mid_hold", acc, 2'b00);
    rst = 1'b0;
    wait_for(1, 0, 20, n);
    chk_int("repress_latency", n, D + 2);
    wait_for(3, 0, 40, n);
    chk_int("relong_after_press", n, L);
    btn = '1;
    step(20);
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 99) < 3) btn[c] = ~btn[c];
      rst = $urandom_range(0, 999) < 2;
      step(1);
    end
    rst = 1'b0;
    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
